// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the handshaked pipeline stage register
//
// Contents:
//   pipe_state_e  : occupancy of the stage (empty, main only, main + skid)
//   CNT_W         : width of the optional statistics counters (PIPE_STATS_EN)
//   payload_width : total bits carried per item (ctrl + all data channels + tag)
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int CNT_W = 16;

  function automatic int payload_width(input int ctrl_w, input int data_w,
                                       input int num_ch, input int tag_w);
    return ctrl_w + num_ch * data_w + tag_w;
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// rtl/pipe_skid_ctrl.sv - occupancy state machine for the two-entry skid stage
//
// Ports:
//   clk, rst        : clock (posedge), asynchronous active-high reset
//   flush           : squash stage contents and the same-cycle input
//   in_valid        : upstream offers an item
//   out_ready       : downstream accepts the main entry
//   in_ready        : registered; high whenever the stage will not be FULL
//   out_valid       : main entry holds a valid item
//   load_main       : capture the input into the main entry
//   load_skid       : capture the input into the skid entry
//   main_from_skid  : move the skid entry into the main entry
//   clr_ctrl        : clear the ctrl field of both entries (flush)
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main,
  output logic load_skid,
  output logic main_from_skid,
  output logic clr_ctrl
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    clr_ctrl       = 1'b0;
    push           = in_valid & in_ready_q;
    pop            = out_valid & out_ready;

    if (flush) begin
      // Flush outranks push and pop: the offered input is simply dropped.
      state_d  = ST_EMPTY;
      clr_ctrl = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so push cannot occur.
          if (pop) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Computed from next state so ready comes straight out of a flop.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised handshaked pipeline stage register with skid buffer
//
// Ports:
//   clk, rst            : clock (posedge), asynchronous active-high reset
//   flush               : synchronous squash of stage contents and same-cycle input
//   in_valid/in_ready   : upstream handshake; in_ready is registered
//   in_ctrl/data/tag    : incoming item; channel k at in_data[k*DATA_W +: DATA_W]
//   out_valid/out_ready : downstream handshake
//   out_ctrl/data/tag   : main entry; out_ctrl forced to 0 while out_valid=0
//   bubble_cnt          : (PIPE_STATS_EN only) saturating count of out_valid=0 && out_ready=1
//   flush_cnt           : (PIPE_STATS_EN only) saturating count of flush cycles
//
// Build option: define PIPE_STATS_EN to add the bubble/flush statistics counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = 12,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int TAG_W     = 15,
  parameter int ZERO_DATA = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_CH*DATA_W-1:0] out_data,
`ifdef PIPE_STATS_EN
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
`endif
  output logic [TAG_W-1:0]         out_tag
);

  localparam int DW = NUM_CH * DATA_W;
  localparam int PW = payload_width(CTRL_W, DATA_W, NUM_CH, TAG_W);

  // Payload layout: {ctrl, data, tag}. On flush the entries are ANDed with
  // FLUSH_KEEP, which always drops ctrl and optionally drops data/tag too.
  localparam logic [PW-1:0] CTRL_CLR   = {{CTRL_W{1'b0}}, {(DW + TAG_W){1'b1}}};
  localparam logic [PW-1:0] FLUSH_KEEP = (ZERO_DATA != 0) ? {PW{1'b0}} : CTRL_CLR;

  logic          load_main, load_skid, main_from_skid, clr_ctrl;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;

  pipe_skid_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main      (load_main),
    .load_skid      (load_skid),
    .main_from_skid (main_from_skid),
    .clr_ctrl       (clr_ctrl)
  );

  assign in_payload = {in_ctrl, in_data, in_tag};

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (clr_ctrl) begin
      main_d = main_q & FLUSH_KEEP;
      skid_d = skid_q & FLUSH_KEEP;
    end else begin
      if (load_main)      main_d = in_payload;
      if (main_from_skid) main_d = skid_q;
      if (load_skid)      skid_d = in_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Outputs come from the main entry only; no input-to-output path.
  assign out_ctrl = out_valid ? main_q[PW-1 -: CTRL_W] : '0;
  assign out_data = main_q[TAG_W +: DW];
  assign out_tag  = main_q[TAG_W-1:0];

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule
